// File: rtl/mem_arbiter_if.sv
// Bundle of the three requester handshakes and the shared memory port seen by mem_arbiter.
// The slave modport is the arbiter's view; master is the CPU/debug/memory side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wmask;
    logic              d_ack;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic [3:0]        dbg_wmask;
    logic              dbg_ack;

    logic [31:0]       rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_rstrb;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_addr, d_wdata, d_wmask,
        input  dbg_req, dbg_addr, dbg_wdata, dbg_wmask,
        input  mem_rdata,
        output if_ack, d_ack, dbg_ack, rdata,
        output mem_addr, mem_wdata, mem_wmask, mem_rstrb
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_addr, d_wdata, d_wmask,
        output dbg_req, dbg_addr, dbg_wdata, dbg_wmask,
        output mem_rdata,
        input  if_ack, d_ack, dbg_ack, rdata,
        input  mem_addr, mem_wdata, mem_wmask, mem_rstrb
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch, load/store and debug.
// Each access is IDLE -> ISSUE -> RESP; contended arbitrations are counted.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] contention_cnt
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned NPORT  = 3;
    localparam int unsigned IDX_W  = 2;

    localparam logic [IDX_W-1:0] P_IF  = 2'd0;
    localparam logic [IDX_W-1:0] P_D   = 2'd1;
    localparam logic [IDX_W-1:0] P_DBG = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [MASK_W-1:0]  wmask_q, wmask_d;
    logic               rstrb_q, rstrb_d;
    logic [NPORT-1:0]   ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NPORT-1:0]   req;
    logic               multi;
    logic [IDX_W-1:0]   sel;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [MASK_W-1:0]  sel_wmask;

    assign req   = {bus.dbg_req, bus.d_req, bus.if_req};
    assign multi = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

    // First requester after the last grantee, in cyclic order if -> d -> dbg.
    always_comb begin
        sel = P_IF;
        case (last_q)
            P_IF:    sel = req[1] ? P_D   : (req[2] ? P_DBG : P_IF);
            P_D:     sel = req[2] ? P_DBG : (req[0] ? P_IF  : P_D);
            default: sel = req[0] ? P_IF  : (req[1] ? P_D   : P_DBG);
        endcase
    end

    // Fetch is always a read, so it contributes no mask and leaves wdata unchanged.
    always_comb begin
        sel_addr  = bus.if_addr;
        sel_wdata = wdata_q;
        sel_wmask = '0;
        case (sel)
            P_D: begin
                sel_addr  = bus.d_addr;
                sel_wdata = bus.d_wdata;
                sel_wmask = bus.d_wmask;
            end
            P_DBG: begin
                sel_addr  = bus.dbg_addr;
                sel_wdata = bus.dbg_wdata;
                sel_wmask = bus.dbg_wmask;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = '0;
        rstrb_d = 1'b0;
        ack_d   = '0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ISSUE;
                    gnt_d   = sel;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wmask_d = sel_wmask;
                    rstrb_d = (sel_wmask == '0);
                    if (multi) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ISSUE: begin
                state_d = RESP;
                case (gnt_q)
                    P_IF:    ack_d[0] = 1'b1;
                    P_D:     ack_d[1] = 1'b1;
                    default: ack_d[2] = 1'b1;
                endcase
            end
            RESP: begin
                state_d = IDLE;
                last_d  = gnt_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= P_DBG;
            gnt_q   <= P_IF;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rstrb_q <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rstrb_q <= rstrb_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_wmask   = wmask_q;
    assign bus.mem_rstrb   = rstrb_q;
    assign bus.if_ack      = ack_q[0];
    assign bus.d_ack       = ack_q[1];
    assign bus.dbg_ack     = ack_q[2];
    // Read data passes straight through from memory during the response cycle only.
    assign bus.rdata       = (state_q == RESP) ? bus.mem_rdata : '0;
    assign busy            = busy_q;
    assign contention_cnt  = cnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin model and a reference memory image.
module tb_mem_arbiter;
    logic        clk;
    logic        rst;
    logic        busy;
    logic [31:0] contention_cnt;
    int          checks;
    int          errors;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .busy           (busy),
        .contention_cnt (contention_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(input int unsigned i);
        if (i == 4) return 32'h0050_0093;
        return (32'(i) * 32'h0001_0203) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Environment memory: 256 words, read data one cycle after the strobe; refilled in reset.
    logic [31:0] mem_arr [256];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= seed_word(32'(i));
        end else begin
            if (bus.mem_rstrb) bus.mem_rdata <= mem_arr[bus.mem_addr[9:2]];
            if (bus.mem_wmask != 4'h0)
                mem_arr[bus.mem_addr[9:2]] <= merge_word(mem_arr[bus.mem_addr[9:2]],
                                                         bus.mem_wdata, bus.mem_wmask);
        end
    end

    // Reference image: words written since the last reset, otherwise the seed pattern.
    logic [31:0] ref_wr [int unsigned];
    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        int unsigned idx;
        idx = 32'(addr[9:2]);
        if (ref_wr.exists(idx)) return ref_wr[idx];
        return seed_word(idx);
    endfunction

    task automatic drop_all();
        bus.if_req  = 1'b0;
        bus.d_req   = 1'b0;
        bus.dbg_req = 1'b0;
        bus.d_wmask   = 4'h0;
        bus.dbg_wmask = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.if_req = 1'b1;  bus.if_addr = 32'h4;
        bus.d_req = 1'b1;   bus.d_addr = 32'h8;   bus.d_wmask = 4'hF;  bus.d_wdata = 32'h1;
        bus.dbg_req = 1'b1; bus.dbg_addr = 32'hC; bus.dbg_wmask = 4'h0; bus.dbg_wdata = 32'h2;
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.dbg_ack, bus.d_ack, bus.if_ack} !== 3'b000) begin
            errors++; $display("FAIL reset_acks: got %b want 000", {bus.dbg_ack, bus.d_ack, bus.if_ack});
        end
        checks++;
        if (bus.mem_rstrb !== 1'b0 || bus.mem_wmask !== 4'h0) begin
            errors++; $display("FAIL reset_strobes: rstrb=%b wmask=%h want 0/0", bus.mem_rstrb, bus.mem_wmask);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (contention_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", contention_cnt);
        end
        checks++;
        if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 || bus.rdata !== 32'd0) begin
            errors++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", bus.mem_addr, bus.mem_wdata, bus.rdata);
        end
        drop_all();
        ref_wr.delete();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_fetch();
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_wmask !== 4'h0 || busy !== 1'b1) begin
            errors++; $display("FAIL fetch_issue: rstrb=%b addr=%h wmask=%h busy=%b want 1/10/0/1",
                               bus.mem_rstrb, bus.mem_addr, bus.mem_wmask, busy);
        end
        @(negedge clk);
        checks++;
        if (bus.if_ack !== 1'b1 || bus.rdata !== 32'h0050_0093 || busy !== 1'b1 || bus.mem_rstrb !== 1'b0) begin
            errors++; $display("FAIL fetch_resp: ack=%b rdata=%h busy=%b rstrb=%b want 1/00500093/1/0",
                               bus.if_ack, bus.rdata, busy, bus.mem_rstrb);
        end
        bus.if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.if_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_done: busy=%b ack=%b want 0/0", busy, bus.if_ack);
        end
    endtask

    task automatic test_store();
        bus.d_req = 1'b1; bus.d_addr = 32'd1000; bus.d_wdata = 32'hDEAD_BEEF; bus.d_wmask = 4'hF;
        @(negedge clk);
        checks++;
        if (bus.mem_wmask !== 4'hF || bus.mem_addr !== 32'd1000 || bus.mem_rstrb !== 1'b0 ||
            bus.mem_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL store_issue: wmask=%h addr=%0d rstrb=%b wdata=%h want F/1000/0/deadbeef",
                               bus.mem_wmask, bus.mem_addr, bus.mem_rstrb, bus.mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (bus.d_ack !== 1'b1 || bus.mem_wmask !== 4'h0) begin
            errors++; $display("FAIL store_resp: ack=%b wmask=%h want 1/0", bus.d_ack, bus.mem_wmask);
        end
        ref_wr[32'd250] = 32'hDEAD_BEEF;
        bus.d_req = 1'b0; bus.d_wmask = 4'h0;
        @(negedge clk);
        bus.d_req = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'd1000) begin
            errors++; $display("FAIL load_issue: rstrb=%b addr=%0d want 1/1000", bus.mem_rstrb, bus.mem_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.d_ack !== 1'b1 || bus.rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL load_resp: ack=%b rdata=%h want 1/deadbeef", bus.d_ack, bus.rdata);
        end
        bus.d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        int m_last;
        logic [2:0] exp_ack;
        logic [31:0] addrs [3];
        logic [31:0] exp_rd;
        addrs[0] = 32'h20; addrs[1] = 32'h124; addrs[2] = 32'h3F0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ref_wr.delete();
        bus.if_req = 1'b1;  bus.if_addr = addrs[0];
        bus.d_req = 1'b1;   bus.d_addr = addrs[1];   bus.d_wmask = 4'h0;
        bus.dbg_req = 1'b1; bus.dbg_addr = addrs[2]; bus.dbg_wmask = 4'h0;
        rst = 1'b1;
        m_last = 2;
        for (int cyc = 1; cyc <= 27; cyc++) begin
            @(negedge clk);
            exp_ack = 3'b000;
            if (cyc % 3 == 2) begin
                m_last = (m_last + 1) % 3;
                exp_ack[m_last] = 1'b1;
            end
            checks++;
            if ({bus.dbg_ack, bus.d_ack, bus.if_ack} !== exp_ack) begin
                errors++; $display("FAIL contention_ack cyc %0d: got %b want %b", cyc,
                                   {bus.dbg_ack, bus.d_ack, bus.if_ack}, exp_ack);
            end
            if (cyc % 3 == 2) begin
                exp_rd = ref_read(addrs[m_last]);
                checks++;
                if (bus.rdata !== exp_rd) begin
                    errors++; $display("FAIL contention_rdata cyc %0d: got %h want %h", cyc, bus.rdata, exp_rd);
                end
            end
            if (cyc % 3 == 1) begin
                checks++;
                if (contention_cnt !== 32'(cyc / 3 + 1)) begin
                    errors++; $display("FAIL contention_cnt cyc %0d: got %0d want %0d", cyc, contention_cnt, cyc / 3 + 1);
                end
            end
        end
        drop_all();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_late_drop();
        logic [31:0] exp_rd;
        int acks;
        bus.dbg_req = 1'b1; bus.dbg_addr = 32'h200; bus.dbg_wmask = 4'h0; bus.dbg_wdata = 32'h0;
        @(negedge clk);
        bus.dbg_req = 1'b0; bus.dbg_addr = 32'h300; bus.dbg_wmask = 4'hF; bus.dbg_wdata = 32'h1234_5678;
        checks++;
        if (bus.mem_addr !== 32'h200 || bus.mem_rstrb !== 1'b1 || bus.mem_wmask !== 4'h0) begin
            errors++; $display("FAIL late_drop_issue: addr=%h rstrb=%b wmask=%h want 200/1/0",
                               bus.mem_addr, bus.mem_rstrb, bus.mem_wmask);
        end
        @(negedge clk);
        exp_rd = ref_read(32'h200);
        checks++;
        if (bus.dbg_ack !== 1'b1 || bus.rdata !== exp_rd || bus.mem_wmask !== 4'h0) begin
            errors++; $display("FAIL late_drop_resp: ack=%b rdata=%h wmask=%h want 1/%h/0",
                               bus.dbg_ack, bus.rdata, bus.mem_wmask, exp_rd);
        end
        bus.dbg_wmask = 4'h0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.dbg_ack === 1'b1 || busy === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL late_drop_extra: got %0d extra busy/ack cycles want 0", acks); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_rd;
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        repeat (2) @(negedge clk);
        bus.if_req = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_addr = 32'h40; bus.d_wmask = 4'h0;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h80;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.d_ack !== 1'b0 || busy !== 1'b0 || bus.mem_rstrb !== 1'b0 || bus.rdata !== 32'h0) begin
            errors++; $display("FAIL reset_mid_abort: ack=%b busy=%b rstrb=%b rdata=%h want 0/0/0/0",
                               bus.d_ack, busy, bus.mem_rstrb, bus.rdata);
        end
        @(negedge clk);
        ref_wr.delete();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_addr !== 32'h80 || bus.d_ack !== 1'b0) begin
            errors++; $display("FAIL reset_mid_first_grant: addr=%h d_ack=%b want 80/0", bus.mem_addr, bus.d_ack);
        end
        @(negedge clk);
        exp_rd = ref_read(32'h80);
        checks++;
        if (bus.if_ack !== 1'b1 || bus.d_ack !== 1'b0 || bus.rdata !== exp_rd || contention_cnt !== 32'd1) begin
            errors++; $display("FAIL reset_mid_if_ack: if_ack=%b d_ack=%b rdata=%h cnt=%0d want 1/0/%h/1",
                               bus.if_ack, bus.d_ack, bus.rdata, contention_cnt, exp_rd);
        end
        bus.if_req = 1'b0;
        repeat (3) @(negedge clk);
        exp_rd = ref_read(32'h40);
        checks++;
        if (bus.d_ack !== 1'b1 || bus.rdata !== exp_rd) begin
            errors++; $display("FAIL reset_mid_d_ack: ack=%b rdata=%h want 1/%h", bus.d_ack, bus.rdata, exp_rd);
        end
        bus.d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random(input int n_cycles);
        logic [2:0]  req_v;
        int          cool [3];
        int          raised_at [3];
        logic [31:0] a [3];
        logic [31:0] wd [3];
        logic [3:0]  wm [3];
        int          m_last, m_free_at, m_ack_at, m_port, nreq, q;
        logic [31:0] m_cnt, m_rd;
        logic        m_is_read, busy_exp;
        logic [2:0]  exp_ack, got_ack;
        drop_all();
        rst = 1'b0;
        @(negedge clk);
        ref_wr.delete();
        rst = 1'b1;
        req_v = 3'b000;
        for (int p = 0; p < 3; p++) begin cool[p] = 0; raised_at[p] = 0; a[p] = 0; wd[p] = 0; wm[p] = 0; end
        m_last = 2; m_free_at = 0; m_ack_at = -10; m_port = 0; m_cnt = 0; m_rd = 0; m_is_read = 1'b0;
        for (int c = 0; c < n_cycles; c++) begin
            exp_ack = 3'b000;
            if (c == m_ack_at) exp_ack[m_port] = 1'b1;
            got_ack = {bus.dbg_ack, bus.d_ack, bus.if_ack};
            checks++;
            if (got_ack !== exp_ack) begin
                errors++; $display("FAIL rand_ack cyc %0d: got %b want %b", c, got_ack, exp_ack);
            end
            if (c == m_ack_at && m_is_read) begin
                checks++;
                if (bus.rdata !== m_rd) begin
                    errors++; $display("FAIL rand_rdata cyc %0d: got %h want %h", c, bus.rdata, m_rd);
                end
            end
            if (c == m_ack_at) begin
                checks++;
                if (c - raised_at[m_port] > 10) begin
                    errors++; $display("FAIL rand_fairness port %0d: waited %0d want <=10", m_port, c - raised_at[m_port]);
                end
            end
            busy_exp = (c == m_ack_at - 1) || (c == m_ack_at);
            checks++;
            if (busy !== busy_exp || contention_cnt !== m_cnt) begin
                errors++; $display("FAIL rand_busy_cnt cyc %0d: busy=%b cnt=%0d want %b/%0d", c, busy, contention_cnt, busy_exp, m_cnt);
            end
            checks++;
            if (bus.mem_rstrb === 1'b1 && bus.mem_wmask !== 4'h0) begin
                errors++; $display("FAIL rand_strobe_excl cyc %0d: rstrb=%b wmask=%h want exclusive", c, bus.mem_rstrb, bus.mem_wmask);
            end
            // Requesters: hold until ack, stay low one cycle after it, then raise at random.
            for (int p = 0; p < 3; p++) begin
                if (exp_ack[p]) begin
                    req_v[p] = 1'b0; cool[p] = 1;
                end else if (!req_v[p]) begin
                    if (cool[p] > 0) cool[p]--;
                    else if ($urandom_range(0, 2) == 0) begin
                        req_v[p] = 1'b1; raised_at[p] = c;
                        a[p]  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                        wd[p] = $urandom;
                        wm[p] = (p == 0 || $urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    end
                end
            end
            bus.if_req = req_v[0];  bus.if_addr = a[0];
            bus.d_req = req_v[1];   bus.d_addr = a[1];   bus.d_wdata = wd[1];   bus.d_wmask = wm[1];
            bus.dbg_req = req_v[2]; bus.dbg_addr = a[2]; bus.dbg_wdata = wd[2]; bus.dbg_wmask = wm[2];
            if (c >= m_free_at && req_v != 3'b000) begin
                nreq = int'(req_v[0]) + int'(req_v[1]) + int'(req_v[2]);
                m_port = -1;
                for (int k = 1; k <= 3; k++) begin
                    q = (m_last + k) % 3;
                    if (m_port < 0 && req_v[q]) m_port = q;
                end
                m_last = m_port; m_ack_at = c + 2; m_free_at = c + 3;
                if (nreq >= 2) m_cnt = m_cnt + 32'd1;
                m_is_read = (wm[m_port] == 4'h0);
                if (m_is_read) m_rd = ref_read(a[m_port]);
                else ref_wr[32'(a[m_port][9:2])] = merge_word(ref_read(a[m_port]), wd[m_port], wm[m_port]);
            end
            @(negedge clk);
        end
        drop_all();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.if_addr = '0; bus.d_addr = '0; bus.dbg_addr = '0;
        bus.d_wdata = '0; bus.dbg_wdata = '0;
        drop_all();
        @(negedge clk);
        test_reset();
        test_single_fetch();
        test_store();
        test_contention();
        test_late_drop();
        test_reset_mid();
        test_random(600);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
